// File: rtl/seg_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_controller
//  Description : Refresh/scan stage for a 4-digit seven-segment display.
//                Latches a 16-bit value, time-multiplexes active-low anodes
//                with blanking dead-time, and commits new values only at
//                frame boundaries so the display never tears.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_scan_controller #(
  parameter int ON_CYCLES   = 50000,
  parameter int DEAD_CYCLES = 1000,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  output logic        an0,
  output logic        an1,
  output logic        an2,
  output logic        an3,
  output logic [7:0]  char_hi,
  output logic [7:0]  char_lo,
  output logic        frame_tick
);

  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       AN_OFF    = 4'hF;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DIGIT = 1'b1
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         idx;
  logic [3:0]         an_q;
  logic [15:0]        pending;
  logic               pend_vld;
  logic               commit;

  // Active-low one-hot anode pattern for a given digit index.
  function automatic logic [3:0] digit_mask(input logic [1:0] d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  // The frame boundary: last ON cycle of digit 3 while scanning.
  assign commit = en && (state == DIGIT) && (cnt == ON_LAST) && (idx == 2'd3);

  assign an0 = an_q[0];
  assign an1 = an_q[1];
  assign an2 = an_q[2];
  assign an3 = an_q[3];

  // Scan FSM, pending/commit path and registered outputs. The anode register
  // is loaded from the next-state values so the pattern tracks the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= 2'd0;
      an_q       <= AN_OFF;
      char_hi    <= 8'h00;
      char_lo    <= 8'h00;
      frame_tick <= 1'b0;
      pending    <= 16'h0000;
      pend_vld   <= 1'b0;
    end else begin
      frame_tick <= 1'b0;

      // A load coinciding with the commit bypasses the pending register.
      if (load && !commit) begin
        pending  <= value;
        pend_vld <= 1'b1;
      end

      if (!en) begin
        state <= BLANK;
        cnt   <= '0;
        idx   <= 2'd0;
        an_q  <= AN_OFF;
      end else begin
        case (state)
          BLANK: begin
            if (cnt == DEAD_LAST) begin
              state <= DIGIT;
              cnt   <= '0;
              an_q  <= digit_mask(idx);
            end else begin
              cnt   <= cnt + CNT_ONE;
              an_q  <= AN_OFF;
            end
          end
          DIGIT: begin
            if (cnt == ON_LAST) begin
              state <= BLANK;
              cnt   <= '0;
              idx   <= idx + 2'd1;
              an_q  <= AN_OFF;
              if (commit) begin
                frame_tick <= 1'b1;
                pend_vld   <= 1'b0;
                if (load) begin
                  char_hi <= value[15:8];
                  char_lo <= value[7:0];
                end else if (pend_vld) begin
                  char_hi <= pending[15:8];
                  char_lo <= pending[7:0];
                end
              end
            end else begin
              cnt   <= cnt + CNT_ONE;
              an_q  <= digit_mask(idx);
            end
          end
          default: begin
            state <= BLANK;
            cnt   <= '0;
            an_q  <= AN_OFF;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_controller
//  Description : Directed self-checking bench for seg_scan_controller with
//                ON_CYCLES=4, DEAD_CYCLES=2 (digit period 6, frame 24).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg_scan_controller;

  logic        clk;
  logic        reset;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic        an0, an1, an2, an3;
  logic [7:0]  char_hi, char_lo;
  logic        frame_tick;

  int          total;
  int          bad;
  logic [15:0] exp_char;

  seg_scan_controller #(
    .ON_CYCLES   (4),
    .DEAD_CYCLES (2),
    .CNT_W       (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .value      (value),
    .an0        (an0),
    .an1        (an1),
    .an2        (an2),
    .an3        (an3),
    .char_hi    (char_hi),
    .char_lo    (char_lo),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and on mismatch count and report it.
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Expected {an3,an2,an1,an0} n clocks after leaving reset or restarting.
  function automatic logic [3:0] exp_an(input int n);
    logic [3:0] one;
    int w;
    int d;
    one = 4'b0001;
    w   = n % 6;
    d   = (n / 6) % 4;
    if (w < 2) return 4'hF;
    return ~(one << d);
  endfunction

  // Advance one clock and check every output against the scan model.
  task automatic cyc(input int n);
    logic [3:0] a;
    @(posedge clk);
    @(negedge clk);
    a = {an3, an2, an1, an0};
    chk($sformatf("an[%0d]", n), {12'h000, a}, {12'h000, exp_an(n)});
    chk($sformatf("tick[%0d]", n), {15'h0000, frame_tick},
        {15'h0000, ((n % 24) == 0) && (n > 0)});
    chk($sformatf("char[%0d]", n), {char_hi, char_lo}, exp_char);
    chk($sformatf("onehot[%0d]", n), {15'h0000, ($countones(~a) <= 1)}, 16'h0001);
  endtask

  // Advance one clock with scanning disabled: everything blank, no tick.
  task automatic cyc_off(input int k);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("off_an[%0d]", k), {12'h000, an3, an2, an1, an0}, 16'h000F);
    chk($sformatf("off_tick[%0d]", k), {15'h0000, frame_tick}, 16'h0000);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    exp_char = 16'h0000;
    reset    = 1'b1;
    en       = 1'b1;
    load     = 1'b0;
    value    = 16'h0000;

    // Reset held for three clocks.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_an", {12'h000, an3, an2, an1, an0}, 16'h000F);
    chk("rst_char", {char_hi, char_lo}, 16'h0000);
    chk("rst_tick", {15'h0000, frame_tick}, 16'h0000);
    reset = 1'b0;

    // Startup and first frame; load ABCD while an1 is low.
    for (int n = 1; n <= 8; n++) cyc(n);
    load = 1'b1; value = 16'hABCD;
    cyc(9);
    load = 1'b0;
    for (int n = 10; n <= 23; n++) cyc(n);
    exp_char = 16'hABCD;
    for (int n = 24; n <= 29; n++) cyc(n);

    // Two loads in one frame: the last one wins.
    load = 1'b1; value = 16'h1234;
    cyc(30);
    load = 1'b0;
    for (int n = 31; n <= 33; n++) cyc(n);
    load = 1'b1; value = 16'h5678;
    cyc(34);
    load = 1'b0;
    for (int n = 35; n <= 47; n++) cyc(n);
    exp_char = 16'h5678;
    for (int n = 48; n <= 71; n++) cyc(n);

    // Load on the exact commit cycle is bypassed straight to the outputs;
    // the following frame boundary leaves it unchanged.
    load = 1'b1; value = 16'h9F0E;
    exp_char = 16'h9F0E;
    cyc(72);
    load = 1'b0;
    for (int n = 73; n <= 110; n++) cyc(n);

    // Disable while an2 is low; a load is still accepted meanwhile.
    en = 1'b0;
    load = 1'b1; value = 16'h4321;
    cyc_off(1);
    load = 1'b0;
    cyc_off(2);
    cyc_off(3);
    chk("off_char", {char_hi, char_lo}, 16'h9F0E);

    // Re-enable: restart from the blank before digit 0.
    en = 1'b1;
    for (int m = 1; m <= 23; m++) cyc(m);
    exp_char = 16'h4321;
    for (int m = 24; m <= 31; m++) cyc(m);

    // Pend a value, then reset mid-frame: outputs clear at once, value lost.
    load = 1'b1; value = 16'hBEEF;
    cyc(32);
    load = 1'b0;
    cyc(33);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_an", {12'h000, an3, an2, an1, an0}, 16'h000F);
    chk("mid_rst_char", {char_hi, char_lo}, 16'h0000);
    chk("mid_rst_tick", {15'h0000, frame_tick}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    exp_char = 16'h0000;
    for (int n = 1; n <= 26; n++) cyc(n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
